// File: rtl/cpa_resolver.sv
// Segmented, pipelined carry-propagate adder: resolves a sum row and a carry row into
// one binary result, settling SEG bits per stage behind a valid/ready handshake.
module cpa_resolver #(
   parameter int    WIDTH  = 32,
   parameter int    SEG    = 8,
   parameter string OUTREG = "FALSE"
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] C,
   input  logic             CIN,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   SUM,
   output logic             PROP_ALL
);

   localparam int NSTAGE   = WIDTH / SEG;
   localparam bit USE_OREG = (OUTREG == "TRUE");

   logic           w_adv;
   logic [WIDTH:0] w_out_sum;
   logic           w_out_prop;
   logic           w_out_vld;

   if ((WIDTH % SEG) != 0) begin : g_bad_cfg
      $error("cpa_resolver: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
   end

   // Stage k sees operand bits from segment k upward (skewed by k stages) and carries the
   // already-settled low segments forward, so every segment leaves the last stage together.
   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      localparam int REM = WIDTH - k * SEG;

      logic [REM-1:0]         w_s;
      logic [REM-1:0]         w_c;
      logic                   w_cin;
      logic                   w_prop_in;
      logic                   w_vld_in;
      logic [SEG:0]           w_seg;
      logic [(k+1)*SEG-1:0]   w_sum_nx;

      logic [(k+1)*SEG-1:0]   r_sum;
      logic                   r_cy;
      logic                   r_prop;
      logic                   r_vld;

      if (k == 0) begin : g_head
         assign w_s       = S;
         assign w_c       = C;
         assign w_cin     = CIN;
         assign w_prop_in = 1'b1;
         assign w_vld_in  = in_valid;
         assign w_sum_nx  = w_seg[SEG-1:0];
      end else begin : g_body
         assign w_s       = g_stage[k-1].g_fwd.r_s;
         assign w_c       = g_stage[k-1].g_fwd.r_c;
         assign w_cin     = g_stage[k-1].r_cy;
         assign w_prop_in = g_stage[k-1].r_prop;
         assign w_vld_in  = g_stage[k-1].r_vld;
         assign w_sum_nx  = {w_seg[SEG-1:0], g_stage[k-1].r_sum};
      end

      assign w_seg = {1'b0, w_s[SEG-1:0]} + {1'b0, w_c[SEG-1:0]} + {{SEG{1'b0}}, w_cin};

      always_ff @(posedge clk) begin
         if (rst) begin
            r_vld <= 1'b0;
         end else if (w_adv) begin
            r_vld <= w_vld_in;
         end
      end

      // NOTE: datapath registers carry no reset; only valid bits do, and outputs are gated by out_valid.
      always_ff @(posedge clk) begin
         if (w_adv) begin
            r_sum  <= w_sum_nx;
            r_cy   <= w_seg[SEG];
            r_prop <= w_prop_in & (&(w_s[SEG-1:0] ^ w_c[SEG-1:0]));
         end
      end

      if (k < NSTAGE - 1) begin : g_fwd
         logic [REM-SEG-1:0] r_s;
         logic [REM-SEG-1:0] r_c;

         always_ff @(posedge clk) begin
            if (w_adv) begin
               r_s <= w_s[REM-1:SEG];
               r_c <= w_c[REM-1:SEG];
            end
         end
      end
   end

   if (USE_OREG) begin : g_oreg
      logic [WIDTH:0] r_o_sum;
      logic           r_o_prop;
      logic           r_o_vld;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_o_vld <= 1'b0;
         end else if (w_adv) begin
            r_o_vld <= g_stage[NSTAGE-1].r_vld;
         end
      end

      always_ff @(posedge clk) begin
         if (w_adv) begin
            r_o_sum  <= {g_stage[NSTAGE-1].r_cy, g_stage[NSTAGE-1].r_sum};
            r_o_prop <= g_stage[NSTAGE-1].r_prop;
         end
      end

      assign w_out_sum  = r_o_sum;
      assign w_out_prop = r_o_prop;
      assign w_out_vld  = r_o_vld;
   end else begin : g_no_oreg
      assign w_out_sum  = {g_stage[NSTAGE-1].r_cy, g_stage[NSTAGE-1].r_sum};
      assign w_out_prop = g_stage[NSTAGE-1].r_prop;
      assign w_out_vld  = g_stage[NSTAGE-1].r_vld;
   end

   // One global enable: the whole pipe moves or the whole pipe holds.
   assign w_adv     = !w_out_vld || out_ready;
   assign in_ready  = w_adv;
   assign out_valid = w_out_vld;
   assign SUM       = w_out_vld ? w_out_sum : '0;
   assign PROP_ALL  = w_out_vld & w_out_prop;

endmodule

// File: tb/tb_cpa_resolver.sv
// Self-checking bench for cpa_resolver: directed cases on the 32/8 configuration plus
// randomized streams on three other parameter sets, all scored against an arithmetic model.
module tb_cpa_resolver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   // ------------------------------------------------------------------ main DUT (32/8/FALSE)
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] s = '0;
   logic [31:0] c = '0;
   logic        cin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [32:0] sum;
   logic        prop_all;

   cpa_resolver #(.WIDTH(32), .SEG(8), .OUTREG("FALSE")) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .S(s), .C(c), .CIN(cin), .out_valid(out_valid), .out_ready(out_ready),
      .SUM(sum), .PROP_ALL(prop_all)
   );

   function automatic logic [33:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic ci);
      logic [32:0] t;
      t = {1'b0, a} + {1'b0, b} + 33'(ci);
      return {((a ^ b) == 32'hFFFF_FFFF), t};
   endfunction

   logic [33:0] m_q[$];
   int          m_rx = 0;
   bit          m_held = 1'b0;
   logic [33:0] m_held_val;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            m_q.delete();
            m_held = 1'b0;
         end else begin
            if (m_held) begin
               check("hold_valid", 66'(out_valid), 66'(1));
               check("hold_sum", 66'({prop_all, sum}), 66'(m_held_val));
            end
            if (out_valid && out_ready) begin
               if (m_q.size() == 0) check("spurious_out", 66'(out_valid), 66'(0));
               else check("stream_sum", 66'({prop_all, sum}), 66'(m_q.pop_front()));
               m_rx++;
            end
            m_held     = out_valid && !out_ready;
            m_held_val = {prop_all, sum};
            if (in_valid && in_ready) m_q.push_back(ref32(s, c, cin));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_measure(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic ci, input int lat_exp, input logic [33:0] exp);
      int n;
      int lat;
      in_valid = 1'b1; s = a; c = b; cin = ci;
      n = 0;
      while (!in_ready && n < 50) begin tick(); n++; end
      check({tag, "_ready"}, 66'(in_ready), 66'(1));
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin tick(); lat++; end
      check({tag, "_lat"}, 66'(lat), 66'(lat_exp));
      check({tag, "_sum"}, 66'({prop_all, sum}), 66'(exp));
      repeat (2) tick();
   endtask

   initial begin
      int          pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      logic        out_hist[14];
      logic [31:0] ops_s[16];
      logic [31:0] ops_c[16];
      logic        ops_ci[16];
      int          sent;
      int          cyc;
      int          rx0;
      int          wt;
      logic        acc;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_out_valid", 66'(out_valid), 66'(0));
      check("rst_sum", 66'(sum), 66'(0));
      check("rst_prop", 66'(prop_all), 66'(0));
      check("rst_in_ready", 66'(in_ready), 66'(1));

      send_measure("basic", 32'h0000_00FF, 32'h0000_0001, 1'b0, 4, {1'b0, 33'h0_0000_0100});
      send_measure("ripple_cin", 32'hFFFF_FFFF, 32'h0, 1'b1, 4, {1'b1, 33'h1_0000_0000});
      send_measure("ripple_alt", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 4, {1'b1, 33'h0_FFFF_FFFF});

      // Streaming: 16 back-to-back operands against a fixed stall pattern.
      for (int i = 0; i < 16; i++) begin
         ops_s[i]  = $urandom;
         ops_c[i]  = ($urandom_range(3) == 0) ? ~ops_s[i] : $urandom;
         ops_ci[i] = 1'($urandom_range(1));
      end
      sent = 0; cyc = 0; rx0 = m_rx;
      while ((sent < 16 || (m_rx - rx0) < 16) && cyc < 300) begin
         out_ready = (cyc >= 5 && cyc <= 8) ? 1'b0 : (cyc > 8 ? (cyc % 2 == 1) : 1'b1);
         in_valid  = (sent < 16);
         if (sent < 16) begin s = ops_s[sent]; c = ops_c[sent]; cin = ops_ci[sent]; end
         @(negedge clk);
         acc = in_valid && in_ready;
         tick();
         if (acc) sent++;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("stream_sent", 66'(sent), 66'(16));
      check("stream_count", 66'(m_rx - rx0), 66'(16));
      repeat (2) tick();

      // Bubbles: out_valid must replay the input pattern four cycles later.
      for (int t = 0; t < 14; t++) begin
         in_valid = (t < 7) ? (pat[t] == 1) : 1'b0;
         s = $urandom; c = $urandom; cin = 1'($urandom_range(1));
         @(negedge clk);
         out_hist[t] = out_valid;
         tick();
      end
      for (int t = 0; t < 14; t++) begin
         check($sformatf("bubble_vld_%0d", t), 66'(out_hist[t]),
               66'((t >= 4 && t - 4 < 7) ? pat[t - 4] : 0));
      end
      repeat (2) tick();

      // Reset with three operands in flight.
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; s = $urandom; c = $urandom; cin = 1'b1;
         tick();
      end
      in_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_valid", 66'(out_valid), 66'(0));
      check("midrst_sum", 66'(sum), 66'(0));
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("midrst_ghost_%0d", k), 66'(out_valid), 66'(0));
      end
      send_measure("post_rst", 32'h1, 32'h1, 1'b0, 4, {1'b0, 33'h2});

      wt = 0;
      while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && wt < 40000) begin
         @(posedge clk);
         wt++;
      end
      check("sweep_done", 66'({g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}), 66'(3'b111));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // ------------------------------------------------------------------ parameter sweep
   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int    W      = (g == 2) ? 64 : 32;
      localparam int    SG     = (g == 0) ? 32 : ((g == 1) ? 4 : 16);
      localparam string OREG_S = (g == 0) ? "FALSE" : "TRUE";
      localparam int    LAT    = (g == 0) ? 1 : ((g == 1) ? 9 : 5);

      logic         rst = 1'b1;
      logic         iv = 1'b0;
      logic         ir;
      logic [W-1:0] a = '0;
      logic [W-1:0] b = '0;
      logic         ci = 1'b0;
      logic         ov;
      logic         orr = 1'b1;
      logic [W:0]   sm;
      logic         pa;
      bit           done = 1'b0;
      int           rx = 0;
      logic [W+1:0] q[$];
      bit           held = 1'b0;
      logic [W+1:0] held_val;

      cpa_resolver #(.WIDTH(W), .SEG(SG), .OUTREG(OREG_S)) u_dut (
         .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
         .S(a), .C(b), .CIN(ci), .out_valid(ov), .out_ready(orr),
         .SUM(sm), .PROP_ALL(pa)
      );

      function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c_in);
         logic [W:0] t;
         t = {1'b0, x} + {1'b0, y} + (W+1)'(c_in);
         return {((x ^ y) == {W{1'b1}}), t};
      endfunction

      initial begin
         forever begin
            @(negedge clk);
            if (rst) begin
               q.delete();
               held = 1'b0;
            end else begin
               if (held) check($sformatf("sw%0d_hold", g), 66'({ov, pa, sm}), 66'({1'b1, held_val}));
               if (ov && orr) begin
                  if (q.size() == 0) check($sformatf("sw%0d_spurious", g), 66'(ov), 66'(0));
                  else check($sformatf("sw%0d_sum", g), 66'({pa, sm}), 66'(q.pop_front()));
                  rx++;
               end
               held     = ov && !orr;
               held_val = {pa, sm};
               if (iv && ir) q.push_back(model(a, b, ci));
            end
         end
      end

      initial begin
         int   lat;
         int   sent;
         int   cyc;
         int   rx0;
         logic acc;

         repeat (3) @(posedge clk);
         #1 rst = 1'b0;
         check($sformatf("sw%0d_rst_ready", g), 66'(ir), 66'(1));
         iv = 1'b1; a = W'({$urandom, $urandom}); b = W'({$urandom, $urandom}); ci = 1'b1;
         @(posedge clk); #1;
         iv = 1'b0;
         lat = 1;
         while (!ov && lat < 40) begin @(posedge clk); #1; lat++; end
         check($sformatf("sw%0d_lat", g), 66'(lat), 66'(LAT));
         repeat (4) begin @(posedge clk); #1; end

         sent = 0; cyc = 0; rx0 = rx;
         while ((sent < 1000 || (rx - rx0) < 1000) && cyc < 20000) begin
            iv  = (sent < 1000) && ($urandom_range(3) != 0);
            orr = ($urandom_range(3) != 0);
            a   = W'({$urandom, $urandom});
            b   = ($urandom_range(7) == 0) ? ~a : W'({$urandom, $urandom});
            ci  = 1'($urandom_range(1));
            @(negedge clk);
            acc = iv && ir;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
         end
         iv = 1'b0; orr = 1'b1;
         check($sformatf("sw%0d_count", g), 66'(rx - rx0), 66'(1000));
         done = 1'b1;
      end
   end

endmodule

// File: doc/cpa_resolver.md
# cpa_resolver

Segmented, pipelined carry-propagate adder that resolves the sum row and carry row produced by a column of compressor counters into one binary result. It sits at the bottom of every compressor tree, after the last counter layer. It settles one SEG-bit carry segment per pipeline stage, so wide results close timing on the fabric carry chain. A valid/ready handshake with full backpressure connects it to the tree and to the downstream consumer.

## Interface
- WIDTH, 32, operand width in bits; must be an integer multiple of SEG.
- SEG, 8, bits resolved per pipeline stage; NSTAGE = WIDTH/SEG.
- OUTREG, "FALSE", "TRUE" adds one output register stage after the final segment.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  S, C and CIN hold a valid operand set.
- in_ready  output  1  block accepts the operand set this cycle.
- S  input  WIDTH  sum row (weight 2^i at bit i).
- C  input  WIDTH  carry row, already weight-aligned to S.
- CIN  input  1  carry into bit 0.
- out_valid  output  1  SUM and PROP_ALL are valid.
- out_ready  input  1  consumer accepts the result.
- SUM  output  WIDTH+1  S + C + CIN; bit WIDTH is the carry out.
- PROP_ALL  output  1  every bit position propagates, i.e. (S ^ C) is all ones for this operand set.

## Operation
- Transfer on input when in_valid && in_ready. Transfer on output when out_valid && out_ready.
- Global stall enable: adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv is 1, every stage register and its valid bit shift by one stage.
  - When adv is 0, every stage holds.
- Stage k (k = 0..NSTAGE-1):
  - Adds segment k of the skewed operands plus the carry registered by stage k-1 (CIN for k = 0).
  - Registers the SEG-bit partial sum and the segment carry-out.
  - Computes segment propagate P_k = &(S_k ^ C_k) and ANDs it into a running PROP_ALL.
- Operand skew: segment j of S/C is delayed j stages before entering its adder.
- Result deskew: the partial sum of segment j is delayed NSTAGE-1-j stages so that all segments leave together.
- The carry out of stage NSTAGE-1 becomes SUM[WIDTH].
- Each stage has a valid bit. Bubbles (adv = 1 with in_valid = 0) propagate as invalid entries. Data in invalid stages is don't-care, but must never reach SUM while out_valid = 0 is violated.
- Arithmetic is unsigned modulo 2^(WIDTH+1); overflow cannot occur.
- If WIDTH % SEG != 0, elaboration fails via $error. SEG = WIDTH is legal and gives NSTAGE = 1.

## Timing
- Latency: L = NSTAGE + (OUTREG == "TRUE" ? 1 : 0) cycles from the input transfer to out_valid, assuming no stall.
- Throughput: one result per cycle when out_ready is held at 1.
- Reset (rst = 1 at a rising edge):
  - All valid bits clear.
  - out_valid = 0, SUM = 0, PROP_ALL = 0.
  - in_ready = 1 in the cycle after reset.
  - Reset mid-stream discards every in-flight operand; no partial result is ever emitted.
- While out_valid && !out_ready: SUM, PROP_ALL and out_valid stay stable and in_ready = 0.
- Simultaneous output and input transfer in one cycle is legal and must not lose or duplicate data.
- in_ready depends combinationally on out_ready. There is no combinational path from S/C to SUM.

## Test plan
- Basic add, WIDTH=32, SEG=8, OUTREG="FALSE":
  - S=0x0000_00FF, C=0x0000_0001, CIN=0 -> out_valid exactly 4 cycles after acceptance, SUM=0x0_0000_0100, PROP_ALL=0.
- Full-width ripple:
  - S=0xFFFF_FFFF, C=0, CIN=1 -> SUM=0x1_0000_0000, PROP_ALL=1.
  - S=0xAAAA_AAAA, C=0x5555_5555, CIN=0 -> SUM=0x0_FFFF_FFFF, PROP_ALL=1.
- Streaming with backpressure:
  - Input: 16 back-to-back random operand sets.
  - Stall pattern: out_ready held 0 for cycles 5-8, then toggled every cycle.
  - Required response: all 16 results match a reference model, in order, with no drops or duplicates; SUM is stable whenever out_valid && !out_ready.
- Bubbles: in_valid pattern 1,0,0,1,1,0,1 with out_ready=1 -> out_valid replays the same pattern delayed by 4 cycles, with correct sums.
- Reset mid-operation: 3 operands in flight, rst asserted for 1 cycle -> out_valid=0, SUM=0 next cycle; no result from those 3 operands ever appears; a new operand 0x1+0x1 returns SUM=0x2 after 4 cycles.
- Parameter sweep (WIDTH, SEG, OUTREG) = (32,32,"FALSE"), (32,4,"TRUE"), (64,16,"TRUE") -> latencies 1, 9 and 5 cycles respectively; 1000 random vectors each match the model.
